// File: rtl/fixed_to_fp32.sv
// fixed_to_fp32: pipelined signed fixed-point to IEEE-754 single-precision
// converter. The input is captured on every edge with stt high; the result
// appears on result_valid four edges later, one sample per cycle.
// Optional build macro FIXED_TO_FP32_RNE_EN selects round-to-nearest-even in
// the pack stage; without it the magnitude is truncated toward zero.
module fixed_to_fp32 #(
  parameter int IN_W   = 32,
  parameter int FRAC_W = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stt,
  input  logic [IN_W-1:0] din,
  output logic [31:0]     result,
  output logic            result_valid,
  output logic            inexact
);

  localparam int             LZ_W    = $clog2(IN_W + 1);
  localparam int             EXT_W   = IN_W + 24;
  localparam logic [8:0]     EXP_TOP = 9'(127 + IN_W - 1 - FRAC_W);
  localparam logic [IN_W-1:0] ONE    = {{(IN_W-1){1'b0}}, 1'b1};

  // Input capture
  logic            cap_valid;
  logic [IN_W-1:0] cap_din;

  // Valid bits for S0..S3
  logic [3:0]      valid_pipe;

  // S0: sign and magnitude
  logic            s0_sign;
  logic [IN_W-1:0] s0_mag;

  // S1: leading-zero count
  logic            s1_sign;
  logic            s1_zero;
  logic [IN_W-1:0] s1_mag;
  logic [LZ_W-1:0] s1_lzc;

  // S2: normalised magnitude and biased exponent
  logic            s2_sign;
  logic            s2_zero;
  logic [IN_W-1:0] s2_norm;
  logic [8:0]      s2_exp;

  // S3: packed output registers
  logic [31:0]     res_q;
  logic            inx_q;

  // Pack-stage combinational signals
  logic [EXT_W-1:0] ext;
  logic [22:0]      frac_r;
  logic [8:0]       exp_r;
  logic [31:0]      pack_result;
  logic             pack_inexact;
`ifdef FIXED_TO_FP32_RNE_EN
  logic             guard;
  logic             sticky;
  logic [23:0]      frac_sum;
`endif
  logic             unused_bits;

  // Number of zeros above the most significant set bit; IN_W for zero.
  function automatic logic [LZ_W-1:0] count_lz(input logic [IN_W-1:0] v);
    logic [LZ_W-1:0] n;
    logic            found;
    n     = LZ_W'(IN_W);
    found = 1'b0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = LZ_W'(IN_W - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Capture the start strobe (cleared by reset) and the sample beside it
  always_ff @(posedge clk) begin
    // NOTE: all clocked state uses non-blocking assignment so every stage reads last cycle's values.
    if (reset) cap_valid <= 1'b0;
    else       cap_valid <= stt;
    cap_din <= din;
  end

  // Shift the valid bit alongside the data; reset flushes everything in flight
  always_ff @(posedge clk) begin
    if (reset) valid_pipe <= '0;
    else       valid_pipe <= {valid_pipe[2:0], cap_valid};
  end

  // S0..S2 datapath: sign/magnitude, leading-zero count, normalise
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; the valid bits alone decide what reaches the output.
    s0_sign <= cap_din[IN_W-1];
    // Most-negative input negates to 2^(IN_W-1), which fits as unsigned.
    s0_mag  <= cap_din[IN_W-1] ? (~cap_din + ONE) : cap_din;

    s1_sign <= s0_sign;
    s1_mag  <= s0_mag;
    s1_zero <= (s0_mag == '0);
    s1_lzc  <= count_lz(s0_mag);

    s2_sign <= s1_sign;
    s2_zero <= s1_zero;
    s2_norm <= s1_mag << s1_lzc;
    s2_exp  <= EXP_TOP - 9'(s1_lzc);
  end

  // S3 pack: extract mantissa below the hidden bit, optional rounding
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    ext          = {s2_norm, 24'd0};
    frac_r       = ext[EXT_W-2 -: 23];
    exp_r        = s2_exp;
    pack_inexact = |ext[IN_W-1:0];
`ifdef FIXED_TO_FP32_RNE_EN
    guard    = ext[IN_W-1];
    sticky   = |ext[IN_W-2:0];
    frac_sum = {1'b0, frac_r} + 24'd1;
    if (guard && (sticky || frac_r[0])) begin
      if (frac_sum[23]) begin
        frac_r = '0;
        exp_r  = s2_exp + 9'd1;
      end else begin
        frac_r = frac_sum[22:0];
      end
    end
`endif
    pack_result = s2_zero ? 32'd0 : {s2_sign, exp_r[7:0], frac_r};
  end

  // The hidden bit and exponent MSB are never needed in the packed word.
  assign unused_bits = ^{exp_r[8], ext[EXT_W-1]};

  // Output register: holds the packed word only on valid cycles, zero otherwise
  always_ff @(posedge clk) begin
    if (reset || !valid_pipe[2]) begin
      res_q <= '0;
      inx_q <= 1'b0;
    end else begin
      res_q <= pack_result;
      inx_q <= pack_inexact && !s2_zero;
    end
  end

  assign result       = res_q;
  assign result_valid = valid_pipe[3];
  assign inexact      = inx_q;

endmodule
